// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring divider with a start/done handshake. One quotient bit
//   is produced per clock from an internal A/Q/M datapath driven by a small
//   FSM (IDLE -> LOAD -> ITER... -> DONE -> IDLE).
//
//   Configuration macro: SIGNED_DIV_EN
//     undefined : unsigned division only, no sign logic present.
//     defined   : two's-complement operands; magnitudes are divided and the
//                 quotient/remainder signs are fixed up on entry to DONE
//                 (truncation toward zero, remainder follows the dividend).
//
//   Ports
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous, active-low reset
//     start        in   1      request, only looked at in IDLE
//     dividend     in   WIDTH  numerator, captured when start is accepted
//     divisor      in   WIDTH  denominator, captured when start is accepted
//     busy         out  1      high while in LOAD or ITER
//     done         out  1      one-cycle pulse while in DONE
//     quotient     out  WIDTH  result, held until the next accepted start
//     remainder    out  WIDTH  result, held until the next accepted start
//     div_by_zero  out  1      set together with done when divisor was zero

module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // A carries one extra bit so the shifted partial remainder can exceed
    // WIDTH bits without corrupting the trial subtraction.
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0] a_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    // One restoring step: shift {A,Q} left, try A-M, keep it only if it did
    // not go negative; the sign bit of the trial becomes the inverted q bit.
    always_comb begin
        a_shift = {a_reg, q_reg[WIDTH-1]};
        trial   = a_shift - {2'b00, m_reg};
        if (trial[WIDTH+1]) begin
            a_next = a_shift[WIDTH:0];
            q_next = {q_reg[WIDTH-2:0], 1'b0};
        end else begin
            a_next = trial[WIDTH:0];
            q_next = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

`ifdef SIGNED_DIV_EN
    // Sign flags are captured in LOAD from the raw operands, before Q and M
    // are replaced by their magnitudes.
    logic neg_quot;
    logic neg_rem;

    assign dividend_mag = q_reg[WIDTH-1] ? -q_reg : q_reg;
    assign divisor_mag  = m_reg[WIDTH-1] ? -m_reg : m_reg;
    assign quot_final   = neg_quot ? -q_next : q_next;
    assign rem_final    = neg_rem ? -a_next[WIDTH-1:0] : a_next[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == LOAD) begin
            neg_quot <= q_reg[WIDTH-1] ^ m_reg[WIDTH-1];
            neg_rem  <= q_reg[WIDTH-1];
        end
    end
`else
    assign dividend_mag = q_reg;
    assign divisor_mag  = m_reg;
    assign quot_final   = q_next;
    assign rem_final    = a_next[WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; done is decoded straight from DONE so
    // it can never outlast that single cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (m_reg == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers. Q and M first hold the raw operands so
    // the divide-by-zero path can return the untouched dividend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg       <= '0;
                        q_reg       <= dividend;
                        m_reg       <= divisor;
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                LOAD: begin
                    if (m_reg == '0) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        a_reg <= '0;
                        q_reg <= dividend_mag;
                        m_reg <= divisor_mag;
                        count <= CW'(WIDTH - 1);
                    end
                end
                ITER: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        quotient  <= quot_final;
                        remainder <= rem_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
